// File: rtl/mips_div_ctrl_pkg.sv
// Shared definitions for the multicycle divider sequencer.
//   DIV_STAGE  : default quotient bits produced per iteration
//   state_e    : sequencer states (IDLE, RUN)
//   abs32      : two's-complement magnitude helper
package mips_div_ctrl_pkg;

  localparam int DIV_STAGE = 2;
  localparam int DIV_ITER  = 32 / DIV_STAGE;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Magnitude of a 32-bit value when neg is set; 0x80000000 maps to itself,
  // which is its correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_div_ctrl_div.sv
// Combinational restoring-divide datapath.
//   mips_div_stage : one quotient bit per instance
//   mips_div       : STAGE chained stages plus final sign correction
// mips_div ports:
//   a             in  dividend/quotient shift value (magnitude)
//   b             in  divisor magnitude
//   remainder_in  in  partial remainder
//   acompl/bcompl in  operand was negated (dividend/divisor)
//   div_ready     in  last iteration: apply sign correction to quotient/remainder
//   quotient_out  out a shifted left STAGE with new quotient bits in LSBs
//   remainder_out out new partial remainder
//   quotient      out sign-corrected quotient (raw when div_ready=0)
//   remainder     out sign-corrected remainder (raw when div_ready=0)
module mips_div_stage (
  input  logic [31:0] rem_in,
  input  logic [31:0] dq_in,
  input  logic [31:0] b,
  output logic [31:0] rem_out,
  output logic [31:0] dq_out
);

  logic [32:0] trial;
  logic [31:0] diff;
  logic        qbit;

  // trial is always below 2*b, so when trial >= b the true difference fits
  // in 32 bits and the modulo-2^32 subtraction gives it exactly.
  always_comb begin
    trial   = {rem_in, dq_in[31]};
    diff    = trial[31:0] - b;
    qbit    = (trial >= {1'b0, b});
    rem_out = qbit ? diff : trial[31:0];
    dq_out  = {dq_in[30:0], qbit};
  end

endmodule

module mips_div #(
  parameter int STAGE = 2
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] remainder_in,
  input  logic        acompl,
  input  logic        bcompl,
  input  logic        div_ready,
  output logic [31:0] quotient_out,
  output logic [31:0] remainder_out,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_c [STAGE+1];
  logic [31:0] dq_c  [STAGE+1];

  assign rem_c[0] = remainder_in;
  assign dq_c[0]  = a;

  for (genvar i = 0; i < STAGE; i++) begin : g_stage
    mips_div_stage u_stage (
      .rem_in  (rem_c[i]),
      .dq_in   (dq_c[i]),
      .b       (b),
      .rem_out (rem_c[i+1]),
      .dq_out  (dq_c[i+1])
    );
  end

  assign quotient_out  = dq_c[STAGE];
  assign remainder_out = rem_c[STAGE];

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  assign quotient  = (div_ready && (acompl ^ bcompl)) ? (~dq_c[STAGE] + 32'd1) : dq_c[STAGE];
  assign remainder = (div_ready && acompl) ? (~rem_c[STAGE] + 32'd1) : rem_c[STAGE];

endmodule

// File: rtl/mips_div_ctrl.sv
// Sequencer for the multicycle DIV/DIVU unit.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : request pulse, sampled only in IDLE, with sign/a/b
//   sign       : 1 = DIV (signed), 0 = DIVU
//   cancel     : pipeline flush; aborts the operation, no done
//   a, b       : dividend, divisor
//   busy       : high while iterating
//   done       : one-cycle pulse when quotient/remainder are updated
//   quotient   : registered quotient (LO)
//   remainder  : registered remainder (HI)
module mips_div_ctrl
  import mips_div_ctrl_pkg::*;
#(
  parameter int STAGE = DIV_STAGE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int ITER  = 32 / STAGE;
  localparam int CNT_W = $clog2(ITER);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acompl_q, acompl_d;
  logic              bcompl_q, bcompl_d;
  logic [31:0]       dq_q, dq_d;
  logic [31:0]       br_q, br_d;
  logic [31:0]       rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       quotient_q, quotient_d;
  logic [31:0]       remainder_q, remainder_d;

  logic              last;
  logic [31:0]       div_qout, div_rout, div_q, div_r;

  assign last = (state_q == RUN) && (cnt_q == CNT_W'(ITER - 1));

  mips_div #(.STAGE(STAGE)) u_div (
    .a             (dq_q),
    .b             (br_q),
    .remainder_in  (rem_q),
    .acompl        (acompl_q),
    .bcompl        (bcompl_q),
    .div_ready     (last),
    .quotient_out  (div_qout),
    .remainder_out (div_rout),
    .quotient      (div_q),
    .remainder     (div_r)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acompl_d    = acompl_q;
    bcompl_d    = bcompl_q;
    dq_d        = dq_q;
    br_d        = br_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        // cancel wins over start so a flushed instruction never launches
        if (start && !cancel) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          acompl_d = sign & a[31];
          bcompl_d = sign & b[31];
          dq_d     = abs32(a, sign & a[31]);
          br_d     = abs32(b, sign & b[31]);
          rem_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          dq_d  = div_qout;
          rem_d = div_rout;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            quotient_d  = div_q;
            remainder_d = div_r;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acompl_q    <= 1'b0;
      bcompl_q    <= 1'b0;
      dq_q        <= '0;
      br_q        <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acompl_q    <= acompl_d;
      bcompl_q    <= bcompl_d;
      dq_q        <= dq_d;
      br_q        <= br_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: doc/mips_div_ctrl.md
Name: mips_div_ctrl

Overview:
Sequencer for the multicycle divider. It latches a DIV/DIVU request, converts signed operands to magnitudes, and iterates the combinational divide datapath (mips_div) a fixed number of cycles, holding the partial remainder and the dividend/quotient shift value in registers. It then captures the sign-corrected quotient/remainder for the HI/LO stage. It sits between the execute-stage issue logic (upstream) and the HI/LO registers (downstream).

Parameters:
STAGE, 2, quotient bits produced per cycle by mips_div; must match the datapath's STAGE
ITER, 32/STAGE (16), localparam, iteration count
CNT_W, 4, localparam, iteration counter width (clog2 of ITER)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
sign  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
cancel  input  1  abort current operation (pipeline flush)
a  input  32  dividend; sampled with start
b  input  32  divisor; sampled with start
busy  output  1  high while iterating
done  output  1  one-cycle pulse, results updated
quotient  output  32  registered quotient (LO)
remainder  output  32  registered remainder (HI)

Behaviour:
- Reset (async, rst=1): state IDLE, cnt=0, busy=0, done=0, quotient=0, remainder=0, internal regs 0. Reset mid-operation abandons it; no done.
- States: IDLE, RUN.
- IDLE: start=1 and cancel=0 -> RUN. Load acompl_r=sign&a[31], bcompl_r=sign&b[31]; dq_r=|a| (two's-complement negate if acompl); b_r=|b|; rem_r=0; cnt=0.
- RUN, each cycle: mips_div driven with a=dq_r, b=b_r, remainder_in=rem_r, acompl=acompl_r, bcompl=bcompl_r, div_ready=(cnt==ITER-1). Stage contract: quotient_out = dq shifted left STAGE with new quotient bits in the LSBs; remainder_out = new partial remainder. Next dq_r<=quotient_out, rem_r<=remainder_out, cnt<=cnt+1.
- On the RUN edge with cnt==ITER-1: quotient<=mips_div quotient, remainder<=mips_div remainder (sign correction applied by mips_div under div_ready); done<=1 for exactly one cycle; state->IDLE.
- Latency: done high in the cycle after the 16th RUN edge, i.e. 16 clocks after the start edge. busy=1 for exactly 16 cycles. Back-to-back: start accepted in the cycle done is high.
- start while busy: ignored, no queuing.
- cancel=1 in RUN: -> IDLE next edge, no done, quotient/remainder keep previous values. cancel has priority over start in IDLE and over completion at cnt==ITER-1.
- Outputs hold the last result until the next completion.
- Magnitudes: |0x80000000| = 0x80000000 (unsigned interpretation); no overflow flag.
- Divide by zero: no special case; result is what the iteration yields (unsigned x/0 -> quotient 0xFFFFFFFF, remainder x).
- Sign rules (from datapath): quotient negated if acompl^bcompl; remainder takes dividend sign.

Decomposition:
- Shared package: ITER/STAGE constants, state encoding (IDLE=1'b0, RUN=1'b1).
- One sub-module instance: mips_div (with its mips_div_stage). Abs conversion and FSM stay in this block.

Test Plan:
- DIVU 100/7, start at cycle 0 -> busy for 16 cycles, done at cycle 16, quotient=14, remainder=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- DIVU 7/0 -> quotient=0xFFFFFFFF, remainder=7.
- DIVU 100/7 then cancel at RUN cycle 5 -> no done, outputs keep prior values. Second start while busy is ignored. start+cancel together in IDLE -> stays IDLE.
- rst asserted at RUN cycle 8 -> busy=0, done=0, quotient=remainder=0 immediately. A new start after reset completes normally. Back-to-back start in the done cycle produces a second done exactly 16 cycles later.
